// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, instruction memory and branch/jump resolution
// for a multi-cycle MIPS datapath.
module instr_fetch_unit #(
    parameter int unsigned IMEM_WORDS       = 128,
    parameter int unsigned CYCLES_PER_INSTR = 4,
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD        = 32'hFFFF_FFFF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic                          alu_zero,
    output logic [31:0]                   instrword,
    output logic                          newinstr,
    output logic [31:0]                   pc,
    output logic                          halted,
    output logic [15:0]                   instr_count
);

    localparam int AW = $clog2(IMEM_WORDS);
    localparam int CW = (CYCLES_PER_INSTR > 2) ? $clog2(CYCLES_PER_INSTR) : 1;
    localparam logic [CW-1:0] CNT_INIT =
        CW'((CYCLES_PER_INSTR > 2) ? CYCLES_PER_INSTR - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    count_q, count_d;

    logic [31:0]    imem [IMEM_WORDS];
    logic [31:0]    fetch_word;
    logic           fetch_fault;
    logic [31:0]    pc4;
    logic [31:0]    br_target;
    logic [31:0]    next_pc;
    logic [5:0]     op;

    // Program port: only honoured while the unit is not executing.
    always_ff @(posedge clock) begin
        if (prog_we && (state_q == S_IDLE || state_q == S_HALT)) begin
            imem[prog_addr] <= prog_data;
        end
    end

    assign fetch_word  = imem[pc_q[AW+1:2]];
    assign fetch_fault = (pc_q[1:0] != 2'b00) ||
                         (pc_q[31:2] >= 30'(IMEM_WORDS));

    assign op        = instr_q[31:26];
    assign pc4       = pc_q + 32'd4;
    assign br_target = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Next PC selection from opcode and datapath zero flag.
    always_comb begin
        next_pc = pc4;
        if (op == 6'd4 && alu_zero) begin
            next_pc = br_target;
        end else if (op == 6'd5 && !alu_zero) begin
            next_pc = br_target;
        end else if (op == 6'd2) begin
            next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
        end
    end

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_fault || fetch_word == HALT_WORD) begin
                    state_d = S_HALT;
                end else begin
                    instr_d = fetch_word;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (CYCLES_PER_INSTR <= 1) begin
                    state_d = S_UPDATE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) state_d = S_UPDATE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_UPDATE: begin
                pc_d = next_pc;
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cnt_q   <= '0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign instrword   = instr_q;
    assign newinstr    = (state_q == S_ISSUE);
    assign pc          = pc_q;
    assign halted      = (state_q == S_HALT);
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
// Default parameters: 128 words, 4 cycles per instruction.
module tb_instr_fetch_unit;

    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
    localparam logic [31:0] ADD_A = 32'h012A_4020;
    localparam logic [31:0] ADD_B = 32'h014B_4820;
    localparam logic [31:0] ADD_C = 32'h016C_5020;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        prog_we;
    logic [6:0]  prog_addr;
    logic [31:0] prog_data;
    logic        alu_zero;
    logic [31:0] instrword;
    logic        newinstr;
    logic [31:0] pc;
    logic        halted;
    logic [15:0] instr_count;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .alu_zero    (alu_zero),
        .instrword   (instrword),
        .newinstr    (newinstr),
        .pc          (pc),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic prog(input int a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a[6:0];
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0);
        end
        total++;
        if (newinstr !== 1'b0) begin
            bad++;
            $display("FAIL reset_newinstr got=%b exp=0", newinstr);
        end
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_halted got=%b exp=0", halted);
        end
        total++;
        if (instr_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_count got=%h exp=0", instr_count);
        end
        total++;
        if (instrword !== 32'h0) begin
            bad++;
            $display("FAIL reset_instrword got=%h exp=0", instrword);
        end
    endtask

    task automatic test_sequential();
        int pulses;
        int cyc [3];
        logic [31:0] pcs [3];
        int exp_cyc [3];
        logic [31:0] exp_pc [3];
        exp_cyc = '{2, 8, 14};
        exp_pc  = '{32'h0, 32'h4, 32'h8};
        pulses  = 0;
        do_reset();
        prog(0, ADD_A);
        prog(1, ADD_B);
        prog(2, ADD_C);
        prog(3, HALTW);
        alu_zero = 1'b0;
        run = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (newinstr === 1'b1) begin
                if (pulses < 3) begin
                    cyc[pulses] = c;
                    pcs[pulses] = pc;
                end
                pulses++;
            end
        end
        run = 1'b0;
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("FAIL seq_pulses got=%0d exp=3", pulses);
        end
        for (int k = 0; k < 3; k++) begin
            if (k < pulses) begin
                total++;
                if (cyc[k] !== exp_cyc[k] || pcs[k] !== exp_pc[k]) begin
                    bad++;
                    $display("FAIL seq_issue%0d cyc=%0d pc=%h exp cyc=%0d pc=%h",
                             k, cyc[k], pcs[k], exp_cyc[k], exp_pc[k]);
                end
            end
        end
        total++;
        if (halted !== 1'b1 || instr_count !== 16'd3) begin
            bad++;
            $display("FAIL seq_halt halted=%b cnt=%0d exp halted=1 cnt=3",
                     halted, instr_count);
        end
        total++;
        if (pc !== 32'hC || instrword !== ADD_C) begin
            bad++;
            $display("FAIL seq_frozen pc=%h iw=%h exp pc=%h iw=%h",
                     pc, instrword, 32'hC, ADD_C);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [5];
        logic        az  [5];
        logic [31:0] exp [5];
        ins = '{32'h1022_0002, 32'h1022_0002, 32'h1422_0002,
                32'h1422_0002, 32'h1022_FFFE};
        az  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp = '{32'h14, 32'h0C, 32'h14, 32'h0C, 32'h04};
        for (int k = 0; k < 5; k++) begin
            do_reset();
            prog(0, ADD_A);
            prog(1, ADD_B);
            prog(2, ins[k]);
            prog(3, HALTW);
            prog(5, HALTW);
            alu_zero = az[k];
            run = 1'b1;
            for (int c = 0; c < 60 && instr_count !== 16'd3; c++) tick();
            run = 1'b0;
            total++;
            if (instr_count !== 16'd3 || pc !== exp[k]) begin
                bad++;
                $display("FAIL branch%0d pc=%h cnt=%0d exp pc=%h cnt=3",
                         k, pc, instr_count, exp[k]);
            end
        end
    endtask

    task automatic test_jump();
        int pulses;
        do_reset();
        prog(0, 32'h0800_0010);
        alu_zero = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 40 && instr_count !== 16'd1; c++) tick();
        run = 1'b0;
        total++;
        if (instr_count !== 16'd1 || pc !== 32'h40) begin
            bad++;
            $display("FAIL jump_pc pc=%h cnt=%0d exp pc=%h cnt=1",
                     pc, instr_count, 32'h40);
        end
        do_reset();
        prog(0, 32'h0800_00C8);
        pulses = 0;
        run = 1'b1;
        for (int c = 0; c < 40 && halted !== 1'b1; c++) begin
            tick();
            if (newinstr === 1'b1) pulses++;
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (newinstr === 1'b1) pulses++;
        end
        run = 1'b0;
        total++;
        if (halted !== 1'b1 || pulses !== 1) begin
            bad++;
            $display("FAIL jump_fault halted=%b pulses=%0d exp halted=1 pulses=1",
                     halted, pulses);
        end
        total++;
        if (pc !== 32'h320 || instr_count !== 16'd1) begin
            bad++;
            $display("FAIL jump_fault_pc pc=%h cnt=%0d exp pc=%h cnt=1",
                     pc, instr_count, 32'h320);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        prog(0, ADD_A);
        prog(1, HALTW);
        alu_zero = 1'b0;
        run = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (instrword !== ADD_A || newinstr !== 1'b0) begin
            bad++;
            $display("FAIL exec_hold iw=%h ni=%b exp iw=%h ni=0",
                     instrword, newinstr, ADD_A);
        end
        reset = 1'b1;
        run   = 1'b0;
        tick();
        reset = 1'b0;
        total++;
        if (pc !== 32'h0 || newinstr !== 1'b0 || instr_count !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset pc=%h ni=%b cnt=%0d exp pc=0 ni=0 cnt=0",
                     pc, newinstr, instr_count);
        end
        tick();
        tick();
        total++;
        if (newinstr !== 1'b0 || pc !== 32'h0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset ni=%b pc=%h h=%b exp ni=0 pc=0 h=0",
                     newinstr, pc, halted);
        end
        run = 1'b1;
        tick();
        tick();
        total++;
        if (newinstr !== 1'b1 || instrword !== ADD_A || pc !== 32'h0) begin
            bad++;
            $display("FAIL reissue ni=%b iw=%h pc=%h exp ni=1 iw=%h pc=0",
                     newinstr, instrword, pc, ADD_A);
        end
        tick();
        prog_we   = 1'b1;
        prog_addr = 7'd0;
        prog_data = 32'hDEAD_BEEF;
        run       = 1'b0;
        tick();
        prog_we   = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (newinstr === 1'b1) pulses++;
        end
        total++;
        if (pc !== 32'h4 || instr_count !== 16'd1 || pulses !== 0 ||
            halted !== 1'b0) begin
            bad++;
            $display("FAIL run_drop pc=%h cnt=%0d pulses=%0d h=%b exp pc=4 cnt=1 pulses=0 h=0",
                     pc, instr_count, pulses, halted);
        end
        do_reset();
        run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        total++;
        if (newinstr !== 1'b1 || instrword !== ADD_A) begin
            bad++;
            $display("FAIL prog_ignored ni=%b iw=%h exp ni=1 iw=%h",
                     newinstr, instrword, ADD_A);
        end
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 7'd0;
        prog_data = 32'd0;
        alu_zero  = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
